// File: rtl/temporal_avg_pool_if.sv
// Sample-stream bundle between the temporal FIR stage and the average-pooling stage.
// The master drives samples and receives pooled results; the slave is the pooling block.
interface temporal_avg_pool_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_valid;
  logic                         x_last;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         y_valid;
  logic                         y_last;
  logic                         frame_done;

  modport master (
    output x_in, x_valid, x_last,
    input  y_out, y_valid, y_last, frame_done
  );

  modport slave (
    input  x_in, x_valid, x_last,
    output y_out, y_valid, y_last, frame_done
  );
endinterface

// File: rtl/temporal_avg_pool.sv
// Streaming 1D average pooling: rounded mean of each POOL_SIZE window, one output every STRIDE
// samples, with windows confined to a single frame.
module temporal_avg_pool #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned POOL_SIZE  = 8,
  parameter int unsigned STRIDE     = 8,
  parameter int unsigned SUM_WIDTH  = DATA_WIDTH + $clog2(POOL_SIZE) + 1
) (
  input logic                  clk,
  input logic                  rst,
  temporal_avg_pool_if.slave   bus
);

  localparam int unsigned ShiftW = $clog2(POOL_SIZE);
  localparam int unsigned FillW  = $clog2(POOL_SIZE + 1);
  localparam int unsigned StrW   = $clog2(STRIDE + 1);

  localparam logic [FillW-1:0]            FillFull = FillW'(POOL_SIZE);
  localparam logic [FillW-1:0]            FillLast = FillW'(POOL_SIZE - 1);
  localparam logic [StrW-1:0]             StrideN  = StrW'(STRIDE);
  localparam logic signed [SUM_WIDTH-1:0] Half     = SUM_WIDTH'(POOL_SIZE / 2);

  logic signed [DATA_WIDTH-1:0] window_q [POOL_SIZE];
  logic [FillW-1:0]             fill_q, fill_d;
  logic [StrW-1:0]              stride_q, stride_d, stride_inc;
  logic signed [SUM_WIDTH-1:0]  sum_q, sum_d, sum_new;
  logic signed [SUM_WIDTH-1:0]  x_ext, old_ext, rounded;
  logic signed [SUM_WIDTH-1:0]  pend_sum_q;
  logic                         emit_d, emit_q;
  logic                         last_q, done_q;
  logic signed [DATA_WIDTH-1:0] y_out_q, y_out_d;
  logic                         y_valid_q, y_last_q, frame_done_q;

  always_comb begin
    x_ext      = {{(SUM_WIDTH - DATA_WIDTH){bus.x_in[DATA_WIDTH-1]}}, bus.x_in};
    old_ext    = '0;
    if (fill_q == FillFull) begin
      old_ext = {{(SUM_WIDTH - DATA_WIDTH){window_q[POOL_SIZE-1][DATA_WIDTH-1]}},
                 window_q[POOL_SIZE-1]};
    end
    sum_new    = sum_q + x_ext - old_ext;
    stride_inc = stride_q + StrW'(1);

    emit_d   = 1'b0;
    fill_d   = fill_q;
    stride_d = stride_q;
    sum_d    = sum_new;

    if (fill_q == FillFull) begin
      // stride_q counts samples since the last emitted window
      if (stride_inc == StrideN) begin
        emit_d   = 1'b1;
        stride_d = '0;
      end else begin
        stride_d = stride_inc;
      end
    end else begin
      fill_d   = fill_q + FillW'(1);
      stride_d = '0;
      emit_d   = (fill_q == FillLast);
    end

    // Emit decision above uses pre-clear state; the frame end only resets what follows.
    if (bus.x_last) begin
      fill_d   = '0;
      stride_d = '0;
      sum_d    = '0;
    end
  end

  assign rounded = pend_sum_q + Half;
  assign y_out_d = DATA_WIDTH'(rounded >>> ShiftW);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(POOL_SIZE); i++) window_q[i] <= '0;
      fill_q       <= '0;
      stride_q     <= '0;
      sum_q        <= '0;
      pend_sum_q   <= '0;
      emit_q       <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      y_out_q      <= '0;
      y_valid_q    <= 1'b0;
      y_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      emit_q <= bus.x_valid & emit_d;
      last_q <= bus.x_valid & bus.x_last;
      done_q <= bus.x_valid & bus.x_last;
      if (bus.x_valid) begin
        window_q[0] <= bus.x_in;
        for (int i = 1; i < int'(POOL_SIZE); i++) window_q[i] <= window_q[i-1];
        fill_q     <= fill_d;
        stride_q   <= stride_d;
        sum_q      <= sum_d;
        pend_sum_q <= sum_new;
      end

      y_valid_q    <= emit_q;
      y_last_q     <= emit_q & last_q;
      frame_done_q <= done_q;
      if (emit_q) y_out_q <= y_out_d;
    end
  end

  assign bus.y_out      = y_out_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.y_last     = y_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_temporal_avg_pool.sv
// Randomised self-checking bench: two pooling instances (window 4, stride 4 and stride 2) share
// one stimulus stream and are compared every cycle against a per-frame arithmetic model.
module tb_temporal_avg_pool;

  localparam int P    = 4;
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  temporal_avg_pool_if #(.DATA_WIDTH(16)) bus_a ();
  temporal_avg_pool_if #(.DATA_WIDTH(16)) bus_b ();

  temporal_avg_pool #(.DATA_WIDTH(16), .POOL_SIZE(P), .STRIDE(4)) u_dut_s4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  temporal_avg_pool #(.DATA_WIDTH(16), .POOL_SIZE(P), .STRIDE(2)) u_dut_s2 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int chk_start = NCYC;

  // Expected events indexed by the cycle in which they must be visible.
  bit ev_valid [2][NCYC];
  int ev_val   [2][NCYC];
  bit ev_last  [2][NCYC];
  bit ev_done  [NCYC];
  bit ev_rst   [NCYC];
  int held     [2];
  int frame    [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic int stride_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic model_sample(input int c, input int v, input bit last);
    int n, s, sum;
    frame.push_back(v);
    n = frame.size();
    for (int k = 0; k < 2; k++) begin
      s = stride_of(k);
      if (n >= P && ((n - P) % s) == 0) begin
        sum = 0;
        for (int i = n - P; i < n; i++) sum += frame[i];
        ev_valid[k][c+2] = 1'b1;
        ev_val[k][c+2]   = floor_div(sum + P / 2, P);
        ev_last[k][c+2]  = last;
      end
    end
    if (last) begin
      ev_done[c+2] = 1'b1;
      frame.delete();
    end
  endtask

  task automatic model_reset(input int c);
    frame.delete();
    for (int t = c + 1; t < c + 5; t++) begin
      ev_done[t] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ev_valid[k][t] = 1'b0;
        ev_last[k][t]  = 1'b0;
      end
    end
    ev_rst[c+1] = 1'b1;
  endtask

  task automatic drive(input int v, input bit valid, input bit last);
    bus_a.x_in = 16'(v); bus_a.x_valid = valid; bus_a.x_last = last;
    bus_b.x_in = 16'(v); bus_b.x_valid = valid; bus_b.x_last = last;
  endtask

  task automatic send(input int v, input bit last);
    @(posedge clk); #1;
    drive(v, 1'b1, last);
    model_sample(cyc, v, last);
  endtask

  // Idle cycles carry junk on x_in/x_last, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(int'($urandom_range(0, 65535)), 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    model_reset(cyc);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_gap(input int v, input bit last);
    idle(int'($urandom_range(0, 3)));
    send(v, last);
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 100)) - 50;
      1:       return int'($urandom_range(0, 65535)) - 32768;
      2:       return 32767;
      default: return -32768;
    endcase
  endfunction

  task automatic check_dut(input string nm, input int k, input int y, input int v, input int l,
                           input int fd);
    if (ev_valid[k][cyc]) held[k] = ev_val[k][cyc];
    check({"y_valid ", nm}, v, int'(ev_valid[k][cyc]));
    check({"y_last ", nm}, l, int'(ev_last[k][cyc]));
    check({"frame_done ", nm}, fd, int'(ev_done[cyc]));
    check({"y_out ", nm}, y, held[k]);
  endtask

  always @(negedge clk) begin
    if (cyc >= chk_start && cyc < NCYC) begin
      if (ev_rst[cyc]) begin
        held[0] = 0;
        held[1] = 0;
      end
      check_dut("s4", 0, int'(bus_a.y_out), int'(bus_a.y_valid), int'(bus_a.y_last),
                int'(bus_a.frame_done));
      check_dut("s2", 1, int'(bus_b.y_out), int'(bus_b.y_valid), int'(bus_b.y_last),
                int'(bus_b.frame_done));
    end
    if (cyc >= NCYC - 8) begin
      $display("FAIL watchdog: got cycle %0d, expected end before %0d", cyc, NCYC - 8);
      $fatal(1, "cycle budget exhausted");
    end
  end

  initial begin
    drive(0, 1'b0, 1'b0);
    held[0] = 0;
    held[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset(cyc);
    chk_start = cyc + 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Continuous 1..8, then signed and extreme windows.
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    idle(3);
    do_reset();
    for (int i = 1; i <= 4; i++) send(-i, 1'b0);
    idle(3);
    do_reset();
    repeat (4) send(32767, 1'b0);
    idle(3);
    do_reset();
    repeat (4) send(-32768, 1'b0);
    idle(3);
    do_reset();

    // Two frames: truncated tail, then an output coinciding with x_last.
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    for (int i = 1; i <= 4; i++) send(10 * i, i == 4);
    idle(4);

    // Same as the first stream with idle gaps.
    do_reset();
    for (int i = 1; i <= 8; i++) send_gap(i, 1'b0);
    idle(3);

    // Reset mid-window discards samples 1..3.
    do_reset();
    for (int i = 1; i <= 3; i++) send(i, 1'b0);
    do_reset();
    for (int i = 5; i <= 8; i++) send(i, 1'b0);
    idle(3);

    // x_last on first sample, short frame, then a full frame.
    send(99, 1'b1);
    for (int i = 1; i <= 3; i++) send(i * 7, i == 3);
    for (int i = 1; i <= 9; i++) send(i * 3, i == 9);
    idle(4);

    // Random frames with gaps and occasional mid-frame resets.
    for (int f = 0; f < 30; f++) begin
      int len;
      len = int'($urandom_range(1, 14));
      for (int i = 1; i <= len; i++) begin
        if ($urandom_range(0, 39) == 0) do_reset();
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        send(rand_val(), i == len);
      end
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
